// File: rtl/serial_sender_fifo_if.sv
// Word-input, serial-handshake and FIFO-status bundle of serial_sender_fifo.
// The producer/receiver side uses master and the sender itself uses slave.
interface serial_sender_fifo_if #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
);
    logic                   Ack;
    logic [DATA_W-1:0]      data;
    logic                   write;
    logic                   start;
    logic                   Request;
    logic                   sdrDataOut;
    logic                   full;
    logic                   empty;
    logic [$clog2(DEPTH):0] count;
    logic                   busy;
    logic                   overflow;
    logic                   done;

    modport master (
        output Ack, data, write, start,
        input  Request, sdrDataOut, full, empty, count, busy, overflow, done
    );

    modport slave (
        input  Ack, data, write, start,
        output Request, sdrDataOut, full, empty, count, busy, overflow, done
    );
endinterface

// File: rtl/serial_sender_fifo.sv
// Word FIFO drained by a four-phase Request/Ack serial transmitter.
// Each word is optionally followed by an even-parity bit, sent LSB or MSB first.
module serial_sender_fifo #(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 16,
    parameter int MSB_FIRST = 0,
    parameter int PARITY_EN = 0
) (
    input  logic                 clk,
    input  logic                 Reset,
    serial_sender_fifo_if.slave  bus
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int FRAME_W = DATA_W + ((PARITY_EN != 0) ? 1 : 0);
    localparam int IDX_W   = $clog2(FRAME_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_W - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        REQ     = 2'd2,
        ACK_LOW = 2'd3
    } state_t;

    function automatic logic even_parity(input logic [DATA_W-1:0] word);
        return ^word;
    endfunction

    // Frame bit 0 is always the first bit on the wire, so the shifter only ever shifts right.
    function automatic logic [FRAME_W-1:0] build_frame(input logic [DATA_W-1:0] word);
        logic [FRAME_W-1:0] f;
        f = {FRAME_W{1'b0}};
        for (int i = 0; i < DATA_W; i++) begin
            f[i] = (MSB_FIRST != 0) ? word[DATA_W-1-i] : word[i];
        end
        if (PARITY_EN != 0) begin
            f[FRAME_W-1] = even_parity(word);
        end
        return f;
    endfunction

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_full;
    logic               r_empty;
    logic               r_overflow;
    state_t             r_state;
    logic [FRAME_W-1:0] r_shift;
    logic [IDX_W-1:0]   r_idx;
    logic               r_request;
    logic               r_sdr;
    logic               r_busy;
    logic               r_done;

    logic               w_push;
    logic               w_pop;
    logic [CNT_W-1:0]   w_count_nxt;
    state_t             w_state_nxt;
    logic               w_request_nxt;
    logic               w_sdr_nxt;
    logic               w_done_nxt;
    logic               w_load;
    logic               w_advance;

    // FIFO push/pop decisions and next occupancy.
    always_comb begin
        w_push = bus.write & ~r_full;
        w_pop  = (r_state == LOAD);
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // FIFO pointers, occupancy flags and sticky overflow.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_wr_ptr   <= {PTR_W{1'b0}};
            r_rd_ptr   <= {PTR_W{1'b0}};
            r_count    <= {CNT_W{1'b0}};
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_W'(DEPTH));
            r_empty <= (w_count_nxt == {CNT_W{1'b0}});
            if (bus.write && r_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage array; contents are irrelevant once the pointers are reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.data;
        end
    end

    // Next state and next registered handshake outputs.
    always_comb begin
        w_state_nxt   = r_state;
        w_request_nxt = r_request;
        w_sdr_nxt     = r_sdr;
        w_done_nxt    = 1'b0;
        w_load        = 1'b0;
        w_advance     = 1'b0;
        case (r_state)
            IDLE: begin
                w_request_nxt = 1'b0;
                if (bus.start && !r_empty) begin
                    w_state_nxt = LOAD;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = REQ;
            end
            REQ: begin
                // Ack only counts once Request is actually visible, so a stale high Ack cannot skip a bit.
                if (r_request && bus.Ack) begin
                    w_request_nxt = 1'b0;
                    w_state_nxt   = ACK_LOW;
                end else begin
                    w_request_nxt = 1'b1;
                    w_sdr_nxt     = r_shift[0];
                end
            end
            ACK_LOW: begin
                w_request_nxt = 1'b0;
                if (bus.Ack) begin
                    w_state_nxt = ACK_LOW;
                end else if (r_idx != LAST_IDX) begin
                    w_advance   = 1'b1;
                    w_state_nxt = REQ;
                end else if (!r_empty) begin
                    w_state_nxt = LOAD;
                end else begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_request_nxt = 1'b0;
                w_state_nxt   = IDLE;
            end
        endcase
    end

    // State register and registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_request <= 1'b0;
            r_sdr     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_request <= w_request_nxt;
            r_sdr     <= w_sdr_nxt;
            r_busy    <= (w_state_nxt != IDLE);
            r_done    <= w_done_nxt;
        end
    end

    // Frame shifter and count of bits already handed over.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_shift <= {FRAME_W{1'b0}};
            r_idx   <= {IDX_W{1'b0}};
        end else if (w_load) begin
            r_shift <= build_frame(r_mem[r_rd_ptr]);
            r_idx   <= {IDX_W{1'b0}};
        end else if (w_advance) begin
            r_shift <= r_shift >> 1;
            r_idx   <= r_idx + IDX_W'(1);
        end else begin
            r_shift <= r_shift;
            r_idx   <= r_idx;
        end
    end

    assign bus.Request    = r_request;
    assign bus.sdrDataOut = r_sdr;
    assign bus.full       = r_full;
    assign bus.empty      = r_empty;
    assign bus.count      = r_count;
    assign bus.busy       = r_busy;
    assign bus.overflow   = r_overflow;
    assign bus.done       = r_done;
endmodule

// File: tb/tb_serial_sender_fifo.sv
// Bench for serial_sender_fifo: dut0 (LSB first, no parity) is tracked by a queue model,
// dut1 (MSB first, parity) by hand-computed expectations.
module tb_serial_sender_fifo;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;

    logic        clk   = 1'b0;
    logic        Reset = 1'b1;
    logic        wr    = 1'b0;
    logic [15:0] wd    = 16'h0000;
    logic        st0   = 1'b0;
    logic        st1   = 1'b0;
    logic        ak0   = 1'b0;
    logic        ak1   = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done0 = 0;
    int n_done1 = 0;

    always #5 clk = ~clk;

    serial_sender_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) b0 ();
    serial_sender_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) b1 ();

    assign b0.write = wr;
    assign b0.data  = wd;
    assign b0.start = st0;
    assign b0.Ack   = ak0;
    assign b1.write = wr;
    assign b1.data  = wd;
    assign b1.start = st1;
    assign b1.Ack   = ak1;

    serial_sender_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .MSB_FIRST(0), .PARITY_EN(0)) dut0 (
        .clk(clk), .Reset(Reset), .bus(b0)
    );
    serial_sender_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .MSB_FIRST(1), .PARITY_EN(1)) dut1 (
        .clk(clk), .Reset(Reset), .bus(b1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model of dut0: accepted words in order; a word's bits are taken when its first Request rises.
    logic [DATA_W-1:0] m_q[$];
    logic              m_bits[$];
    logic              m_ovf = 1'b0;

    initial begin
        logic [DATA_W-1:0] w;
        logic p_req  = 1'b0;
        logic p_sdr  = 1'b0;
        logic p_busy = 1'b0;
        logic p_done = 1'b0;
        logic eb;
        forever begin
            @(posedge clk);
            #1;
            if (Reset) begin
                m_q.delete();
                m_bits.delete();
                m_ovf = 1'b0;
            end else if (wr) begin
                if (m_q.size() < DEPTH) m_q.push_back(wd);
                else m_ovf = 1'b1;
            end
            if (b0.Request && !p_req) begin
                if (m_bits.size() == 0 && m_q.size() != 0) begin
                    w = m_q.pop_front();
                    for (int i = 0; i < DATA_W; i++) m_bits.push_back(w[i]);
                end
                if (m_bits.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_request: got Request=1, expected no Request (no word pending)");
                end else begin
                    eb = m_bits.pop_front();
                    chk("serial_bit", {31'd0, b0.sdrDataOut}, {31'd0, eb});
                end
            end
            if (b0.Request && p_req) chk("bit_stable", {31'd0, b0.sdrDataOut}, {31'd0, p_sdr});
            if (!b0.busy && !b0.Request) begin
                chk("count", {27'd0, b0.count}, m_q.size());
                chk("empty", {31'd0, b0.empty}, {31'd0, (m_q.size() == 0)});
                chk("full", {31'd0, b0.full}, {31'd0, (m_q.size() == DEPTH)});
                chk("overflow", {31'd0, b0.overflow}, {31'd0, m_ovf});
                chk("word_complete", m_bits.size(), 32'd0);
            end
            if (b0.done) begin
                n_done0++;
                chk("done_at_busy_fall", {29'd0, p_busy, b0.busy, p_done}, 32'h4);
            end
            if (b1.done) n_done1++;
            p_req  = b0.Request;
            p_sdr  = b0.sdrDataOut;
            p_busy = b0.busy;
            p_done = b0.done;
        end
    end

    task automatic hs(input bit sel, output logic b, output bit ok);
        int n;
        ok = 1'b1;
        b  = 1'b0;
        n  = 0;
        while (((sel ? b1.Request : b0.Request) == 1'b0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if ((sel ? b1.Request : b0.Request) == 1'b0) begin
            ok = 1'b0;
            return;
        end
        b = sel ? b1.sdrDataOut : b0.sdrDataOut;
        if (sel) ak1 = 1'b1;
        else ak0 = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((sel ? b1.Request : b0.Request) == 1'b1) && n < 40);
        if ((sel ? b1.Request : b0.Request) == 1'b1) ok = 1'b0;
        ak0 = 1'b0;
        ak1 = 1'b0;
    endtask

    task automatic hs_word(input bit sel, input int nbits, output logic [31:0] v);
        logic b;
        bit   ok;
        v = 32'd0;
        for (int i = 0; i < nbits; i++) begin
            hs(sel, b, ok);
            if (!ok) begin
                chk("handshake_ok", {31'd0, ok}, 32'd1);
                return;
            end
            v[i] = b;
        end
    endtask

    task automatic push_words(input logic [15:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            wr = 1'b1;
            wd = first + 16'(i);
            @(negedge clk);
        end
        wr = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        Reset = 1'b1;
        repeat (cycles) @(negedge clk);
        Reset = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected $finish before 1 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] v;
        logic [31:0] v2;
        int d0;
        int n;
        bit exp_a5c3[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                             1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        // Reset held two cycles.
        @(negedge clk);
        do_reset(2);
        chk("rst_request", {31'd0, b0.Request}, 32'd0);
        chk("rst_sdr", {31'd0, b0.sdrDataOut}, 32'd0);
        chk("rst_full", {31'd0, b0.full}, 32'd0);
        chk("rst_empty", {31'd0, b0.empty}, 32'd1);
        chk("rst_count", {27'd0, b0.count}, 32'd0);
        chk("rst_busy", {31'd0, b0.busy}, 32'd0);
        chk("rst_overflow", {31'd0, b0.overflow}, 32'd0);
        chk("rst_done", {31'd0, b0.done}, 32'd0);

        // 0xA5C3 LSB first, with start-to-Request latency.
        push_words(16'hA5C3, 1);
        d0  = n_done0;
        st0 = 1'b1;
        @(negedge clk);
        st0 = 1'b0;
        chk("busy_after_start", {31'd0, b0.busy}, 32'd1);
        chk("req_lat_1", {31'd0, b0.Request}, 32'd0);
        @(negedge clk);
        chk("req_lat_2", {31'd0, b0.Request}, 32'd0);
        @(negedge clk);
        chk("req_lat_3", {31'd0, b0.Request}, 32'd1);
        hs_word(1'b0, 16, v);
        for (int i = 0; i < 16; i++) chk("a5c3_bit", {31'd0, v[i]}, {31'd0, exp_a5c3[i]});
        repeat (3) @(negedge clk);
        chk("a5c3_done", n_done0 - d0, 32'd1);
        chk("a5c3_idle", {31'd0, b0.busy}, 32'd0);

        // Ack held high after the first Request.
        push_words(16'h0002, 1);
        st0 = 1'b1;
        @(negedge clk);
        st0 = 1'b0;
        n = 0;
        while (!b0.Request && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("first_req_seen", {31'd0, b0.Request}, 32'd1);
        chk("first_bit", {31'd0, b0.sdrDataOut}, 32'd0);
        ak0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("ack_held_req_low", {31'd0, b0.Request}, 32'd0);
        end
        ak0 = 1'b0;
        hs_word(1'b0, 15, v);
        chk("second_bit", {31'd0, v[0]}, 32'd1);
        chk("rest_of_0002", v, 32'h0001);
        repeat (3) @(negedge clk);

        // Word written mid-transmission joins the same transmission.
        push_words(16'h1234, 1);
        d0  = n_done0;
        st0 = 1'b1;
        @(negedge clk);
        st0 = 1'b0;
        hs_word(1'b0, 4, v);
        push_words(16'h5678, 1);
        hs_word(1'b0, 12, v2);
        chk("mid_word1", {v2[11:0], v[3:0]}, 32'h1234);
        hs_word(1'b0, 16, v);
        chk("mid_word2", v, 32'h5678);
        repeat (3) @(negedge clk);
        chk("mid_done", n_done0 - d0, 32'd1);

        // Overfill to 18 words, then drain all 16.
        do_reset(2);
        push_words(16'h1000, 18);
        chk("ovf_count", {27'd0, b0.count}, 32'd16);
        chk("ovf_full", {31'd0, b0.full}, 32'd1);
        chk("ovf_flag", {31'd0, b0.overflow}, 32'd1);
        d0  = n_done0;
        st0 = 1'b1;
        @(negedge clk);
        st0 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            hs_word(1'b0, 16, v);
            chk("drain_word", v, 32'h1000 + 32'(k));
        end
        repeat (10) @(negedge clk);
        chk("drain_done", n_done0 - d0, 32'd1);
        chk("drain_empty", {31'd0, b0.empty}, 32'd1);

        // Reset mid-word with write and start in the same cycle.
        do_reset(1);
        push_words(16'hBEEF, 1);
        push_words(16'h1111, 1);
        push_words(16'h2222, 1);
        st0 = 1'b1;
        @(negedge clk);
        st0 = 1'b0;
        hs_word(1'b0, 3, v);
        chk("beef_3bits", v, 32'h7);
        d0    = n_done0;
        Reset = 1'b1;
        wr    = 1'b1;
        wd    = 16'h3333;
        st0   = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        wr    = 1'b0;
        st0   = 1'b0;
        chk("midrst_request", {31'd0, b0.Request}, 32'd0);
        chk("midrst_busy", {31'd0, b0.busy}, 32'd0);
        chk("midrst_count", {27'd0, b0.count}, 32'd0);
        st0 = 1'b1;
        @(negedge clk);
        st0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("empty_start_no_req", {31'd0, b0.Request}, 32'd0);
        end
        chk("empty_start_no_done", n_done0 - d0, 32'd0);

        // Parity, MSB first on dut1: 0x0007 -> thirteen 0s, three 1s, parity 1.
        do_reset(1);
        push_words(16'h0007, 1);
        d0  = n_done1;
        st1 = 1'b1;
        @(negedge clk);
        st1 = 1'b0;
        hs_word(1'b1, 17, v);
        chk("parity_frame", v, 32'h1E000);
        chk("parity_bit17", {31'd0, v[16]}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("parity_no_18th", {31'd0, b1.Request}, 32'd0);
        end
        chk("parity_done", n_done1 - d0, 32'd1);
        chk("parity_idle", {31'd0, b1.busy}, 32'd0);
        chk("parity_empty", {31'd0, b1.empty}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_sender_fifo.md
SERIAL_SENDER_FIFO -- requirements
Module: serial_sender_fifo

Interface
REQ-001 The block SHALL have the parameter DATA_W, default 16, meaning the word width in bits.
REQ-002 The block SHALL have the parameter DEPTH, default 16, meaning the FIFO depth in words (power of 2, at least 2).
REQ-003 The block SHALL have the parameter MSB_FIRST, default 0, meaning bit order (0: LSB first, 1: MSB first).
REQ-004 The block SHALL have the parameter PARITY_EN, default 0, meaning append one even-parity bit after each word when 1.
REQ-005 The block SHALL have one clock and a synchronous active-high reset, as ports clk and Reset.
REQ-006 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-007 Port Reset, input, 1 bit: synchronous active-high reset.
REQ-008 Port Ack, input, 1 bit: receiver acknowledge for the current bit.
REQ-009 Port data, input, DATA_W bits: word to enqueue.
REQ-010 Port write, input, 1 bit: enqueue data this cycle.
REQ-011 Port start, input, 1 bit: begin transmitting the buffered words.
REQ-012 Port Request, output, 1 bit: a bit is valid on sdrDataOut.
REQ-013 Port sdrDataOut, output, 1 bit: serial data.
REQ-014 Port full, output, 1 bit: FIFO holds DEPTH words.
REQ-015 Port empty, output, 1 bit: FIFO holds 0 words.
REQ-016 Port count, output, $clog2(DEPTH)+1 bits: FIFO occupancy.
REQ-017 Port busy, output, 1 bit: a transmission is in progress.
REQ-018 Port overflow, output, 1 bit: sticky flag, set when a write was dropped.
REQ-019 Port done, output, 1 bit: one-cycle pulse when transmission ends.

Function
REQ-020 All outputs SHALL be registered.
REQ-021 write=1 with full=0 SHALL push data at the clock edge; write=1 with full=1 SHALL drop the word and set overflow.
REQ-022 A simultaneous push and pop SHALL both occur and leave count unchanged; a push while full and popping SHALL be dropped.
REQ-023 The state machine SHALL have the states IDLE, LOAD, REQ and ACK_LOW.
REQ-024 IDLE: start=1 with empty=0 SHALL move to LOAD; start with empty=1 SHALL be ignored with no done pulse.
REQ-025 LOAD: the FIFO head SHALL be popped into the shift register, bit index cleared, and the state SHALL move to REQ.
REQ-026 REQ: Request=1 and sdrDataOut=current bit SHALL hold stable until Ack=1 is sampled, then the state SHALL move to ACK_LOW with Request=0 on the next cycle.
REQ-027 ACK_LOW: Request=0 SHALL hold until Ack=0 is sampled; then the next bit SHALL go to REQ, or the end of word with empty=0 SHALL go to LOAD, or the end of word with empty=1 SHALL go to IDLE with done=1 for one cycle.
REQ-028 A word SHALL be DATA_W bits, plus one parity bit (XOR of the word) when PARITY_EN=1, in the order set by MSB_FIRST.
REQ-029 Request SHALL rise 2 cycles after the edge that samples start.
REQ-030 busy SHALL be 1 in LOAD, REQ and ACK_LOW, and 0 in IDLE.
REQ-031 start while busy=1 SHALL be ignored.
REQ-032 Words written during a transmission SHALL be sent in the same transmission if present at the end-of-word check.
REQ-033 Ack held high across words SHALL NOT produce a new Request until Ack=0 is sampled.
REQ-034 FIFO pointers SHALL wrap modulo DEPTH.

Reset
REQ-035 Reset=1 at an edge SHALL force IDLE and clear the FIFO, count=0, empty=1, full=0, overflow=0, Request=0, sdrDataOut=0, busy=0 and done=0, including mid-transfer; words in flight SHALL be discarded.
REQ-036 Reset SHALL take priority over write and start in the same cycle.

Verification
REQ-037 Reset held for 2 cycles -> all outputs at their reset values, and empty=1.
REQ-038 Write 0x1000..0x1011 (18 words), DEPTH=16 -> count=16, full=1, overflow=1; start plus 256 handshakes -> words 0x1000..0x100F sent in order, 0x1010 and 0x1011 absent, done pulse, empty=1.
REQ-039 One word 0xA5C3, MSB_FIRST=0, PARITY_EN=0 -> 16 Requests with bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, then done.
REQ-040 PARITY_EN=1, word 0x0007 -> 17 Requests, and the 17th bit=1.
REQ-041 Ack held high for 5 cycles after the first Request -> Request stays 0 until Ack=0, then the second bit is presented.
REQ-042 Reset asserted after the 3rd bit of 0xBEEF with 2 words queued -> next cycle Request=0, busy=0, count=0; a following start with empty=1 produces no Request.
